// File: rtl/clk_pwmdiv_pkg.sv
// Shared types and helpers for the multi-channel clock divider / PWM generator.
package clk_pwmdiv_pkg;

  typedef enum logic [0:0] {
    CH_IDLE,
    CH_RUN
  } ch_state_e;

  // Width of the channel-select field; never narrower than one bit.
  function automatic int unsigned calc_ch_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_pwmdiv_if.sv
// Configuration write port: valid/ready handshake carrying channel, period and high time.
interface clk_pwmdiv_if
  import clk_pwmdiv_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CH_W     = calc_ch_w(CHANNELS)
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [WIDTH-1:0] cfg_period;
  logic [WIDTH-1:0] cfg_high;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_period,
    output cfg_high,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_period,
    input  cfg_high,
    output cfg_ready
  );

endinterface

// File: rtl/clk_pwmdiv_ch.sv
// One divider/PWM channel: period counter, active and pending config, registered output and tick.
module clk_pwmdiv_ch
  import clk_pwmdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             run_req,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_period,
  input  logic [WIDTH-1:0] wr_high,
  output logic             clock_out,
  output logic             period_tick,
  output logic             pend
);

  ch_state_e        state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] p_per_q, p_per_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d;
  logic             pend_q, pend_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;

  logic             run_cond;
  logic             wrap;
  logic [WIDTH-1:0] hi_eff;

  assign run_cond = run_req & (per_q != '0);
  assign wrap     = (cnt_q == per_q - WIDTH'(1));

  // Next-state: counter advance, wrap-time config swap, output compare.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    hi_d    = hi_q;
    p_per_d = p_per_q;
    p_hi_d  = p_hi_q;
    pend_d  = pend_q;
    out_d   = out_q;
    tick_d  = 1'b0;
    hi_eff  = hi_q;
    unique case (state_q)
      CH_IDLE: begin
        out_d = 1'b0;
        if (wr_en) begin
          per_d = wr_period;
          hi_d  = wr_high;
        end
        if (run_cond) begin
          state_d = CH_RUN;
          cnt_d   = '0;
          out_d   = (hi_q != '0);
        end
      end
      CH_RUN: begin
        if (!run_cond) begin
          state_d = CH_IDLE;
          cnt_d   = '0;
          out_d   = 1'b0;
          if (pend_q) begin
            per_d  = p_per_q;
            hi_d   = p_hi_q;
            pend_d = 1'b0;
          end else if (wr_en) begin
            // Channel is stopping, so the write lands directly as for an idle channel.
            per_d = wr_period;
            hi_d  = wr_high;
          end
        end else begin
          cnt_d  = wrap ? '0 : cnt_q + WIDTH'(1);
          tick_d = wrap;
          if (wrap && pend_q) begin
            per_d  = p_per_q;
            hi_d   = p_hi_q;
            hi_eff = p_hi_q;
            pend_d = 1'b0;
          end
          // pend is clear whenever a write is accepted, so this never collides with the swap.
          if (wr_en) begin
            p_per_d = wr_period;
            p_hi_d  = wr_high;
            pend_d  = 1'b1;
          end
          out_d = (cnt_d < hi_eff);
        end
      end
      default: state_d = CH_IDLE;
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      hi_q    <= '0;
      p_per_q <= '0;
      p_hi_q  <= '0;
      pend_q  <= 1'b0;
      out_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      hi_q    <= hi_d;
      p_per_q <= p_per_d;
      p_hi_q  <= p_hi_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
    end
  end

  assign clock_out   = out_q;
  assign period_tick = tick_q;
  assign pend        = pend_q;

endmodule

// File: rtl/clk_pwmdiv.sv
// Multi-channel clock divider / PWM generator with double-buffered configuration.
module clk_pwmdiv
  import clk_pwmdiv_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CH_W     = calc_ch_w(CHANNELS)
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] ch_enable,
  clk_pwmdiv_if.slave         cfg,
  output logic [CHANNELS-1:0] clock_out,
  output logic [CHANNELS-1:0] period_tick,
  output logic [WIDTH-1:0]    n_clks
);

  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] wr_en;
  logic                ready;
  logic [WIDTH-1:0]    n_clks_q;

  // Ready decode: out-of-range channels never match, so ready stays low for them.
  always_comb begin
    ready = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) ready = ~pend[i];
    end
  end

  assign cfg.cfg_ready = ready;

  // Write-enable fan-out to the addressed channel.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_en[i] = cfg.cfg_valid & ready & (cfg.cfg_ch == CH_W'(i));
    end
  end

  // Free-running debug counter of enabled edges.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) n_clks_q <= '0;
    else if (enable) n_clks_q <= n_clks_q + WIDTH'(1);
  end

  assign n_clks = n_clks_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clk_pwmdiv_ch #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clock_in   (clock_in),
      .reset      (reset),
      .run_req    (enable & ch_enable[g]),
      .wr_en      (wr_en[g]),
      .wr_period  (cfg.cfg_period),
      .wr_high    (cfg.cfg_high),
      .clock_out  (clock_out[g]),
      .period_tick(period_tick[g]),
      .pend       (pend[g])
    );
  end

endmodule

// File: tb/tb_clk_pwmdiv.sv
// Directed self-checking bench for clk_pwmdiv.
module tb_clk_pwmdiv;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned CHANNELS = 4;

  logic                clock_in = 1'b0;
  logic                reset;
  logic                enable;
  logic [CHANNELS-1:0] ch_enable;
  logic [CHANNELS-1:0] clock_out;
  logic [CHANNELS-1:0] period_tick;
  logic [WIDTH-1:0]    n_clks;

  int checks   = 0;
  int failures = 0;

  clk_pwmdiv_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) cfg_bus ();

  clk_pwmdiv #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS)
  ) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .enable     (enable),
    .ch_enable  (ch_enable),
    .cfg        (cfg_bus),
    .clock_out  (clock_out),
    .period_tick(period_tick),
    .n_clks     (n_clks)
  );

  always #5 clock_in = ~clock_in;

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Single write to a channel whose pending slot is free; consumes one edge.
  task automatic cfg_write(input int ch, input int per, input int hi);
    cfg_bus.cfg_ch     = 2'(ch);
    cfg_bus.cfg_period = 32'(per);
    cfg_bus.cfg_high   = 32'(hi);
    cfg_bus.cfg_valid  = 1'b1;
    chk1("write_ready", cfg_bus.cfg_ready, 1'b1);
    step();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  initial begin
    int c;
    reset              = 1'b1;
    enable             = 1'b0;
    ch_enable          = '0;
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_ch     = '0;
    cfg_bus.cfg_period = '0;
    cfg_bus.cfg_high   = '0;
    step();
    step();
    chk("rst_clock_out", 32'(clock_out), 32'd0);
    chk("rst_tick", 32'(period_tick), 32'd0);
    chk("rst_n_clks", n_clks, 32'd0);
    chk1("rst_ready", cfg_bus.cfg_ready, 1'b1);
    reset = 1'b0;

    // ch0: period 4, high 1 -> 1,0,0,0 repeating.
    cfg_write(0, 4, 1);
    chk("n_clks_hold", n_clks, 32'd0);
    ch_enable = 4'b0001;
    enable    = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      c = (k - 1) % 4;
      chk1("ch0_out", clock_out[0], c == 0);
      chk1("ch0_tick", period_tick[0], (k > 1) && (c == 0));
      chk("n_clks_count", n_clks, 32'(k));
    end

    // ch1: 10/5 running, retuned mid-period to 6/2.
    cfg_write(1, 10, 5);
    ch_enable = 4'b0011;
    step();
    chk1("ch1_entry_out", clock_out[1], 1'b1);
    chk1("ch1_entry_tick", period_tick[1], 1'b0);
    for (int j = 1; j <= 3; j++) begin
      step();
      chk1("ch1_old_high", clock_out[1], 1'b1);
    end
    cfg_bus.cfg_ch     = 2'd1;
    cfg_bus.cfg_period = 32'd6;
    cfg_bus.cfg_high   = 32'd2;
    cfg_bus.cfg_valid  = 1'b1;
    chk1("ch1_ready_pre", cfg_bus.cfg_ready, 1'b1);
    step();
    cfg_bus.cfg_valid = 1'b0;
    chk1("ch1_cnt4_out", clock_out[1], 1'b1);
    chk1("ch1_ready_pend", cfg_bus.cfg_ready, 1'b0);
    for (int j = 5; j <= 9; j++) begin
      step();
      chk1("ch1_old_low", clock_out[1], 1'b0);
      chk1("ch1_ready_wait", cfg_bus.cfg_ready, 1'b0);
    end
    step();
    chk1("ch1_swap_out", clock_out[1], 1'b1);
    chk1("ch1_swap_tick", period_tick[1], 1'b1);
    chk1("ch1_swap_ready", cfg_bus.cfg_ready, 1'b1);
    for (int m = 1; m <= 6; m++) begin
      step();
      c = m % 6;
      chk1("ch1_new_out", clock_out[1], c < 2);
      chk1("ch1_new_tick", period_tick[1], c == 0);
    end

    // ch1: write on the exact wrap edge waits one full period.
    for (int m = 1; m <= 5; m++) step();
    cfg_bus.cfg_period = 32'd3;
    cfg_bus.cfg_high   = 32'd1;
    cfg_bus.cfg_valid  = 1'b1;
    chk1("wrapw_ready", cfg_bus.cfg_ready, 1'b1);
    step();
    cfg_bus.cfg_valid = 1'b0;
    chk1("wrapw_tick", period_tick[1], 1'b1);
    chk1("wrapw_out", clock_out[1], 1'b1);
    chk1("wrapw_ready_low", cfg_bus.cfg_ready, 1'b0);
    for (int m = 1; m <= 5; m++) begin
      step();
      chk1("wrapw_old_out", clock_out[1], m < 2);
      chk1("wrapw_old_tick", period_tick[1], 1'b0);
    end
    step();
    chk1("wrapw_swap_tick", period_tick[1], 1'b1);
    chk1("wrapw_swap_out", clock_out[1], 1'b1);
    chk1("wrapw_swap_ready", cfg_bus.cfg_ready, 1'b1);
    step();
    chk1("wrapw_new_c1", clock_out[1], 1'b0);
    step();
    chk1("wrapw_new_c2", clock_out[1], 1'b0);
    step();
    chk1("wrapw_new_c0", clock_out[1], 1'b1);
    chk1("wrapw_new_tick", period_tick[1], 1'b1);

    // ch2 high=0 -> constant low; ch3 high>=period -> constant high.
    cfg_write(2, 5, 0);
    cfg_write(3, 8, 8);
    ch_enable = 4'b1111;
    for (int s = 1; s <= 10; s++) begin
      step();
      chk1("ch2_const_low", clock_out[2], 1'b0);
      chk1("ch3_const_high", clock_out[3], 1'b1);
      chk1("ch3_tick", period_tick[3], s == 9);
    end

    // ch3 period=0 -> stays idle with no ticks.
    ch_enable = 4'b0111;
    step();
    cfg_write(3, 0, 3);
    ch_enable = 4'b1111;
    for (int s = 1; s <= 6; s++) begin
      step();
      chk1("ch3_off_out", clock_out[3], 1'b0);
      chk1("ch3_off_tick", period_tick[3], 1'b0);
    end

    // ch2 stopped with a pending write: pending applied, restart from cnt 0.
    cfg_write(2, 4, 2);
    chk1("ch2_pend_ready", cfg_bus.cfg_ready, 1'b0);
    ch_enable = 4'b1011;
    step();
    chk1("ch2_stop_out", clock_out[2], 1'b0);
    chk1("ch2_stop_ready", cfg_bus.cfg_ready, 1'b1);
    ch_enable = 4'b1111;
    step();
    chk1("ch2_restart_out", clock_out[2], 1'b1);
    chk1("ch2_restart_tick", period_tick[2], 1'b0);
    for (int s = 1; s <= 5; s++) begin
      step();
      c = s % 4;
      chk1("ch2_new_out", clock_out[2], c < 2);
      chk1("ch2_new_tick", period_tick[2], c == 0);
    end

    // Asynchronous reset mid-run clears everything before the next edge.
    #2;
    reset = 1'b1;
    #1;
    chk("async_clock_out", 32'(clock_out), 32'd0);
    chk("async_tick", 32'(period_tick), 32'd0);
    chk("async_n_clks", n_clks, 32'd0);
    chk1("async_ready", cfg_bus.cfg_ready, 1'b1);
    #1;
    reset = 1'b0;
    step();
    chk("post_rst_out", 32'(clock_out), 32'd0);
    chk("post_rst_n_clks", n_clks, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_pwmdiv.md
# clk_pwmdiv

- Multi-channel programmable clock divider / PWM generator; next generation of the single-output `clk_freqdiv`.
- `CHANNELS` independent outputs, each with its own period and high time, clocked from one input clock.
- Configuration goes through a valid/ready write port. Updates to a running channel are double-buffered and take effect only at that channel's period boundary, so outputs never glitch.
- Sits between the board clock and LED/PWM/strobe consumers; a shared free-running cycle counter is kept for debug.

## Interface
- `WIDTH`, 32: width of counters, period and high-time fields.
- `CHANNELS`, 4: number of output channels (≥1).
- `CH_W`, `$clog2(CHANNELS)` (min 1): width of the channel-select field.

Ports:
- `clock_in`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `enable`  in  1  global run enable.
- `ch_enable`  in  CHANNELS  per-channel run enable.
- `cfg_valid`  in  1  config write request.
- `cfg_ready`  out  1  config write can be accepted.
- `cfg_ch`  in  CH_W  target channel.
- `cfg_period`  in  WIDTH  period in `clock_in` cycles; 0 = channel off.
- `cfg_high`  in  WIDTH  high cycles per period.
- `clock_out`  out  CHANNELS  registered divided/PWM outputs.
- `period_tick`  out  CHANNELS  one-cycle pulse on each period wrap.
- `n_clks`  out  WIDTH  count of edges with `enable` high.

## Operation
- Per channel: active regs `per`, `hi`; pending regs `p_per`, `p_hi`, `pend`; counter `cnt`; state IDLE or RUN.
- RUN condition = `enable & ch_enable[i] & (per != 0)`, sampled each edge.
  - IDLE→RUN: `cnt <= 0`, `clock_out[i] <= (hi != 0)`.
  - RUN→IDLE: `cnt <= 0`, `clock_out[i] <= 0`.
- In RUN each edge:
  - Advance `cnt <= (cnt == per-1) ? 0 : cnt+1`.
  - Then `clock_out[i] <= (new cnt < hi)`.
  - `hi >= per` gives a constant-high output; `hi == 0` gives a constant-low output.
- Wrap edge (`cnt == per-1` in RUN): `period_tick[i] <= 1` for one cycle.
  - If `pend`, load `per/hi` from pending and clear `pend`. The new `hi` already governs `clock_out` on this edge.
- `per == 1` wraps every cycle: `period_tick` stays high, output = `(hi != 0)`.
- Write acceptance:
  - Accepted when `cfg_valid & cfg_ready`.
  - `cfg_ready = (cfg_ch < CHANNELS) & ~pend[cfg_ch]`. Out-of-range channel: `cfg_ready` is 0 and the write is never accepted.
- Accepted write, target IDLE: loads `per/hi` directly on that edge.
- Accepted write, target RUN: loads pending and sets `pend`.
  - If the same edge is a wrap of that channel, the write is not applied at this wrap; it waits for the next wrap.
- Channel leaving RUN with `pend` set: pending is applied on that edge and `pend` clears.
- `n_clks` increments each edge with `enable` high, wraps modulo 2^WIDTH, holds when `enable` is low.

## Timing
- Reset values: `clock_out` = 0, `period_tick` = 0, `n_clks` = 0, all `cnt/per/hi/pend` = 0 (all channels IDLE), `cfg_ready` = 1 for in-range `cfg_ch`.
- `clock_out` and `period_tick` are registered: one-cycle latency from the sampling edge.
- `cfg_ready` is combinational from `pend` and `cfg_ch`.
- Latency from an accepted write to a running channel: up to one full old period plus 0 cycles. The change appears on the first wrap edge after acceptance.
- Latency from a write to an IDLE channel plus enable: the output follows the new config from the first RUN edge.
- Async reset mid-period forces all outputs low immediately; the first period after release starts at `cnt` 0.
- Several channels may wrap on the same edge; each is independent.

## Structure
- Package `clk_pwmdiv_pkg`: channel state enum (`CH_IDLE`, `CH_RUN`) and the `CH_W` derivation function.
- Sub-module `clk_pwmdiv_ch`: one channel (counter, active/pending regs, state, output and tick regs), generated `CHANNELS` times.
- Top level holds `cfg_ready` decode, write-enable fan-out and `n_clks`.

## Test plan
- Reset, then write ch0 `period=4`, `high=1`, enable -> `clock_out[0]` = 1,0,0,0 repeating; `period_tick[0]` high every 4th cycle; `n_clks` counts 1,2,3…
- Ch1 running `period=10`, `high=5`; write `period=6`, `high=2` mid-period -> `cfg_ready` low for ch1 until the wrap; the next period is 2 high / 4 low with no runt pulse.
- Write issued on the exact wrap edge of a running channel -> old config persists one more full period, then the new one applies.
- `high=0` -> output constant 0; `high >= period` (e.g. 8, 8) -> constant 1; `period=0` -> channel IDLE, output 0, no ticks.
- Drop `ch_enable[2]` with `pend` set -> output low next cycle, pending applied; re-enable -> the new config starts from `cnt` 0.
- Assert `reset` asynchronously mid-run -> all outputs 0 before the next edge; `n_clks` = 0; `cfg_ready` = 1.
